// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared constants, IRQ state type and pointer-width helper
package io_port_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

    // One extra MSB beyond the address bits separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_port_if.sv
// rtl/io_port_if.sv - processor/external port bundle with master and slave views
interface io_port_if
    import io_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] ext_in_data;
    logic              ext_in_valid;
    logic              ext_in_ready;
    logic [DATA_W-1:0] input_port;
    logic              in_consume;
    logic [DATA_W-1:0] out_port;
    logic              out_strobe;
    logic [DATA_W-1:0] ext_out_data;
    logic              ext_out_valid;
    logic              ext_out_ready;
    logic              interrupt_signal;
    logic              irq_enable;
    logic              in_underflow;
    logic              out_overflow;

    modport master (
        output ext_in_data, ext_in_valid, in_consume, out_port, out_strobe,
               ext_out_ready, irq_enable,
        input  ext_in_ready, input_port, ext_out_data, ext_out_valid,
               interrupt_signal, in_underflow, out_overflow
    );

    modport slave (
        input  ext_in_data, ext_in_valid, in_consume, out_port, out_strobe,
               ext_out_ready, irq_enable,
        output ext_in_ready, input_port, ext_out_data, ext_out_valid,
               interrupt_signal, in_underflow, out_overflow
    );
endinterface

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock FIFO with wrap-bit pointers
module io_sync_fifo
    import io_port_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [ptr_w(DEPTH)-1:0]  count
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign count   = wr_q - rd_q;
    assign head    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; readers never look at it while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

    // Pointers wrap modulo 2*DEPTH through natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - I/O port FIFOs and interrupt pulser; IO_LOOPBACK_EN adds loopback
module io_port_controller
    import io_port_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IN_DEPTH    = 8,
    parameter int OUT_DEPTH   = 8,
    parameter int IRQ_PULSE   = 2,
    parameter int IRQ_HOLDOFF = 4
) (
    input  logic     clk,
    input  logic     rst,
`ifdef IO_LOOPBACK_EN
    input  logic     loopback,
`endif
    io_port_if.slave bus
);
    localparam int IN_PW   = ptr_w(IN_DEPTH);
    localparam int OUT_PW  = ptr_w(OUT_DEPTH);
    localparam int CNT_MAX = (IRQ_PULSE > IRQ_HOLDOFF) ? IRQ_PULSE : IRQ_HOLDOFF;
    localparam int CW      = ptr_w(CNT_MAX);

    logic              lb;
    logic              in_push, in_pop, in_full, in_empty, in_going_empty;
    logic [DATA_W-1:0] in_push_data, in_head;
    logic [IN_PW-1:0]  in_count;
    logic              out_push, out_pop, out_full, out_empty;
    logic [DATA_W-1:0] out_head;
    logic [OUT_PW-1:0] out_count;
    logic              ready_w, strobe_full;

    irq_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              served_q, served_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              underflow_q, overflow_q;

`ifdef IO_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    // In loopback the processor's OUT writes feed the input FIFO and the external source is shut out.
    assign ready_w        = rst && !in_full && !lb;
    assign in_push        = lb ? (bus.out_strobe && !in_full) : (bus.ext_in_valid && ready_w);
    assign in_push_data   = lb ? bus.out_port : bus.ext_in_data;
    assign in_pop         = bus.in_consume && !in_empty;
    assign in_going_empty = in_pop && !in_push && (in_count == IN_PW'(1));
    assign out_push       = bus.out_strobe && !lb && !out_full;
    assign out_pop        = bus.ext_out_ready && (out_count != '0);
    assign strobe_full    = lb ? in_full : out_full;

    io_sync_fifo #(.DEPTH(IN_DEPTH), .WIDTH(DATA_W)) u_in_fifo (
        .clk(clk), .rst_n(rst), .push(in_push), .push_data(in_push_data), .pop(in_pop),
        .full(in_full), .empty(in_empty), .head(in_head), .count(in_count)
    );

    io_sync_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_W)) u_out_fifo (
        .clk(clk), .rst_n(rst), .push(out_push), .push_data(bus.out_port), .pop(out_pop),
        .full(out_full), .empty(out_empty), .head(out_head), .count(out_count)
    );

    assign bus.ext_in_ready     = ready_w;
    assign bus.input_port       = in_empty ? last_q : in_head;
    assign bus.ext_out_data     = out_empty ? '0 : out_head;
    assign bus.ext_out_valid    = !out_empty;
    assign bus.interrupt_signal = (state_q == ASSERT);
    assign bus.in_underflow     = underflow_q;
    assign bus.out_overflow     = overflow_q;
    assign last_d               = in_pop ? in_head : last_q;

    // IRQ sequencing: one pulse per empty->non-empty episode, then a quiet holdoff.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        served_d = served_q;
        case (state_q)
            IDLE: begin
                if (bus.irq_enable && !in_empty && !served_q) begin
                    state_d  = ASSERT;
                    served_d = 1'b1;
                    cnt_d    = CW'(IRQ_PULSE - 1);
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = HOLDOFF;
                    cnt_d   = CW'(IRQ_HOLDOFF - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (in_going_empty) served_d = 1'b0;
    end

    // IRQ state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
        end
    end

    // Last popped word and sticky error flags (cleared only by reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q      <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            last_q      <= last_d;
            underflow_q <= underflow_q | (bus.in_consume && in_empty);
            overflow_q  <= overflow_q | (bus.out_strobe && strobe_full);
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - directed self-checking bench for io_port_controller
module tb_io_port_controller;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
`ifdef IO_LOOPBACK_EN
    logic loopback;
`endif

    io_port_if #(.DATA_W(DW)) bus ();

    io_port_controller #(
        .DATA_W(DW), .IN_DEPTH(8), .OUT_DEPTH(8), .IRQ_PULSE(2), .IRQ_HOLDOFF(4)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef IO_LOOPBACK_EN
        .loopback(loopback),
`endif
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ext_in_data   = '0;
        bus.ext_in_valid  = 1'b0;
        bus.in_consume    = 1'b0;
        bus.out_port      = '0;
        bus.out_strobe    = 1'b0;
        bus.ext_out_ready = 1'b0;
        bus.irq_enable    = 1'b0;
`ifdef IO_LOOPBACK_EN
        loopback = 1'b0;
`endif
    endtask

    task automatic do_reset();
        clear_inputs();
        tick();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++; if (bus.ext_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", bus.ext_in_ready); end
        checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.ext_out_valid); end
        checks++; if (bus.input_port !== 16'h0000) begin errors++; $display("FAIL rst_input_port: got %h expected 0000", bus.input_port); end
        checks++; if (bus.ext_out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h expected 0000", bus.ext_out_data); end
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", bus.interrupt_signal); end
        checks++; if ({bus.in_underflow, bus.out_overflow} !== 2'b00) begin errors++; $display("FAIL rst_stickies: got %b expected 00", {bus.in_underflow, bus.out_overflow}); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.ext_in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b expected 1", bus.ext_in_ready); end
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.irq_enable   = 1'b1;
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h00A1;
        bus.out_strobe   = 1'b1;
        bus.out_port     = 16'h0055;
        tick();
        bus.out_strobe  = 1'b0;
        bus.ext_in_data = 16'h00A2;
        tick();
        bus.ext_in_data = 16'h00A3;
        tick();
        bus.ext_in_valid = 1'b0;
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL mid_pre_irq: got %b expected 1", bus.interrupt_signal); end
        checks++; if (bus.ext_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_out_valid: got %b expected 1", bus.ext_out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.ext_out_valid); end
        checks++; if (bus.input_port !== 16'h0000) begin errors++; $display("FAIL mid_input_port: got %h expected 0000", bus.input_port); end
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", bus.interrupt_signal); end
        bus.irq_enable = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        checks++; if (bus.input_port !== 16'h0000) begin errors++; $display("FAIL mid_in_empty: got %h expected 0000", bus.input_port); end
        checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_empty: got %b expected 0", bus.ext_out_valid); end
        checks++; if (bus.ext_in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.ext_in_ready); end
    endtask

    task automatic test_irq_basic();
        do_reset();
        bus.irq_enable   = 1'b1;
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h1234;
        tick();
        checks++; if (bus.input_port !== 16'h1234) begin errors++; $display("FAIL irq_head: got %h expected 1234", bus.input_port); end
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL irq_latency0: got %b expected 0", bus.interrupt_signal); end
        bus.ext_in_data = 16'hBEEF;
        tick();
        bus.ext_in_valid = 1'b0;
        bus.irq_enable   = 1'b0;
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL irq_pulse1: got %b expected 1", bus.interrupt_signal); end
        tick();
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL irq_pulse2_no_truncate: got %b expected 1", bus.interrupt_signal); end
        bus.irq_enable = 1'b1;
        tick();
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL irq_pulse_end: got %b expected 0", bus.interrupt_signal); end
        bus.in_consume = 1'b1;
        tick();
        checks++; if (bus.input_port !== 16'hBEEF) begin errors++; $display("FAIL irq_second_word: got %h expected beef", bus.input_port); end
        tick();
        bus.in_consume = 1'b0;
        checks++; if (bus.input_port !== 16'hBEEF) begin errors++; $display("FAIL irq_hold_last: got %h expected beef", bus.input_port); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL irq_quiet_empty[%0d]: got %b expected 0", k, bus.interrupt_signal); end
        end
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h7777;
        tick();
        bus.ext_in_valid = 1'b0;
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL irq_repush_latency: got %b expected 0", bus.interrupt_signal); end
        tick();
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL irq_repush_pulse: got %b expected 1", bus.interrupt_signal); end
        checks++; if (bus.in_underflow !== 1'b0) begin errors++; $display("FAIL irq_no_underflow: got %b expected 0", bus.in_underflow); end
    endtask

    task automatic test_in_fifo_full();
        logic [DW-1:0] exp;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.ext_in_valid = 1'b1;
            bus.ext_in_data  = DW'(16'h0010 + i);
            tick();
        end
        checks++; if (bus.ext_in_ready !== 1'b1) begin errors++; $display("FAIL infull_ready7: got %b expected 1", bus.ext_in_ready); end
        bus.ext_in_data = 16'h0017;
        bus.in_consume  = 1'b1;
        tick();
        bus.in_consume = 1'b0;
        checks++; if (bus.input_port !== 16'h0011) begin errors++; $display("FAIL infull_pushpop_head: got %h expected 0011", bus.input_port); end
        checks++; if (bus.ext_in_ready !== 1'b1) begin errors++; $display("FAIL infull_pushpop_count7: got %b expected 1", bus.ext_in_ready); end
        bus.ext_in_data = 16'h0018;
        tick();
        checks++; if (bus.ext_in_ready !== 1'b0) begin errors++; $display("FAIL infull_ready8: got %b expected 0", bus.ext_in_ready); end
        bus.ext_in_data = 16'h0019;
        tick();
        bus.ext_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = DW'(16'h0011 + i);
            checks++; if (bus.input_port !== exp) begin errors++; $display("FAIL infull_drain[%0d]: got %h expected %h", i, bus.input_port, exp); end
            bus.in_consume = 1'b1;
            tick();
        end
        bus.in_consume = 1'b0;
        checks++; if (bus.input_port !== 16'h0018) begin errors++; $display("FAIL infull_ninth_dropped: got %h expected 0018", bus.input_port); end
        checks++; if (bus.in_underflow !== 1'b0) begin errors++; $display("FAIL infull_underflow_pre: got %b expected 0", bus.in_underflow); end
        bus.in_consume = 1'b1;
        tick();
        bus.in_consume = 1'b0;
        checks++; if (bus.in_underflow !== 1'b1) begin errors++; $display("FAIL infull_underflow: got %b expected 1", bus.in_underflow); end
        checks++; if (bus.input_port !== 16'h0018) begin errors++; $display("FAIL infull_underflow_hold: got %h expected 0018", bus.input_port); end
    endtask

    task automatic test_out_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bus.out_port   = DW'(i);
            bus.out_strobe = 1'b1;
            tick();
            if (i == 1) begin
                checks++; if (bus.ext_out_valid !== 1'b1) begin errors++; $display("FAIL out_latency_valid: got %b expected 1", bus.ext_out_valid); end
                checks++; if (bus.ext_out_data !== 16'h0001) begin errors++; $display("FAIL out_latency_data: got %h expected 0001", bus.ext_out_data); end
            end
        end
        bus.out_strobe = 1'b0;
        checks++; if (bus.out_overflow !== 1'b1) begin errors++; $display("FAIL out_overflow: got %b expected 1", bus.out_overflow); end
        bus.ext_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (bus.ext_out_valid !== 1'b1 || bus.ext_out_data !== DW'(i)) begin errors++; $display("FAIL out_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, bus.ext_out_valid, bus.ext_out_data, DW'(i)); end
            tick();
        end
        bus.ext_out_ready = 1'b0;
        checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL out_drained: got %b expected 0", bus.ext_out_valid); end
    endtask

    task automatic test_overflow_no_rescue();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.out_port   = DW'(16'h0021 + i);
            bus.out_strobe = 1'b1;
            tick();
        end
        checks++; if (bus.out_overflow !== 1'b0) begin errors++; $display("FAIL norescue_pre: got %b expected 0", bus.out_overflow); end
        bus.out_port      = 16'h00AA;
        bus.ext_out_ready = 1'b1;
        tick();
        bus.out_strobe = 1'b0;
        checks++; if (bus.out_overflow !== 1'b1) begin errors++; $display("FAIL norescue_flag: got %b expected 1", bus.out_overflow); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (bus.ext_out_data !== DW'(16'h0022 + i)) begin errors++; $display("FAIL norescue_drain[%0d]: got %h expected %h", i, bus.ext_out_data, DW'(16'h0022 + i)); end
            tick();
        end
        bus.ext_out_ready = 1'b0;
        checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL norescue_empty: got %b expected 0", bus.ext_out_valid); end
    endtask

    task automatic test_holdoff_refill();
        do_reset();
        bus.irq_enable   = 1'b1;
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h000A;
        tick();
        bus.ext_in_valid = 1'b0;
        tick();
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL hold_first_pulse: got %b expected 1", bus.interrupt_signal); end
        bus.in_consume = 1'b1;
        tick();
        bus.in_consume = 1'b0;
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL hold_pulse_tail: got %b expected 1", bus.interrupt_signal); end
        tick();
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL hold_enter: got %b expected 0", bus.interrupt_signal); end
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h000B;
        tick();
        bus.ext_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL hold_quiet[%0d]: got %b expected 0", k, bus.interrupt_signal); end
            tick();
        end
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL hold_second_pulse1: got %b expected 1", bus.interrupt_signal); end
        tick();
        checks++; if (bus.interrupt_signal !== 1'b1) begin errors++; $display("FAIL hold_second_pulse2: got %b expected 1", bus.interrupt_signal); end
        tick();
        checks++; if (bus.interrupt_signal !== 1'b0) begin errors++; $display("FAIL hold_second_end: got %b expected 0", bus.interrupt_signal); end
    endtask

`ifdef IO_LOOPBACK_EN
    task automatic test_loopback();
        do_reset();
        loopback       = 1'b1;
        bus.out_port   = 16'h00A5;
        bus.out_strobe = 1'b1;
        #1;
        checks++; if (bus.ext_in_ready !== 1'b0) begin errors++; $display("FAIL lb_ready: got %b expected 0", bus.ext_in_ready); end
        tick();
        bus.out_strobe = 1'b0;
        checks++; if (bus.input_port !== 16'h00A5) begin errors++; $display("FAIL lb_input_port: got %h expected 00a5", bus.input_port); end
        checks++; if (bus.ext_out_valid !== 1'b0) begin errors++; $display("FAIL lb_out_valid: got %b expected 0", bus.ext_out_valid); end
        loopback = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        clear_inputs();
        test_reset();
        test_reset_midstream();
        test_irq_basic();
        test_in_fifo_full();
        test_out_overflow();
        test_overflow_no_rescue();
        test_holdoff_refill();
`ifdef IO_LOOPBACK_EN
        test_loopback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Peripheral-side partner of the processor's I/O ports and interrupt input.
- Buffers externally arriving words in an input FIFO and presents the head word on the processor's input port; pops the head on each IN retire.
- Captures OUT writes into an output FIFO drained by an external valid/ready sink.
- Raises the processor interrupt line once per input-data episode.

Parameters:
- DATA_W, 16, width of port words.
- IN_DEPTH, 8, input FIFO depth (power of 2, >=2).
- OUT_DEPTH, 8, output FIFO depth (power of 2, >=2).
- IRQ_PULSE, 2, cycles interrupt_signal is held high (>=1).
- IRQ_HOLDOFF, 4, minimum low cycles after a pulse before re-arming (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ext_in_data  in  DATA_W  word from external source.
- ext_in_valid  in  1  source has word.
- ext_in_ready  out  1  input FIFO can accept.
- input_port  out  DATA_W  value seen by processor IN instruction.
- in_consume  in  1  one-cycle strobe per retired IN instruction.
- out_port  in  DATA_W  processor output-port value.
- out_strobe  in  1  one-cycle strobe when OUT retires (outport enable at WB).
- ext_out_data  out  DATA_W  head of output FIFO.
- ext_out_valid  out  1  output FIFO non-empty.
- ext_out_ready  in  1  sink accepts.
- interrupt_signal  out  1  interrupt request to processor.
- irq_enable  in  1  interrupt generation enable.
- in_underflow  out  1  sticky: in_consume while input FIFO empty.
- out_overflow  out  1  sticky: out_strobe while output FIFO full.

Behaviour:
- Reset (rst low, async): both FIFOs empty, pointers 0, input_port=0, ext_out_data=0, ext_out_valid=0, ext_in_ready=0 while rst low then 1, interrupt_signal=0, stickies 0, IRQ FSM=IDLE, irq_served=0. Mid-operation reset discards all buffered words.
- Input FIFO:
  - push when ext_in_valid && ext_in_ready; ext_in_ready = !in_full.
  - pop when in_consume && !in_empty.
  - Simultaneous push/pop both take effect; count unchanged.
  - input_port = head word combinationally when non-empty; otherwise holds the last popped word (0 after reset).
  - in_consume when empty: no pop, in_underflow set.
- Output FIFO:
  - push when out_strobe && !out_full, data=out_port sampled that cycle.
  - out_strobe when full: word dropped, out_overflow set. A pop in the same cycle does not rescue the push.
  - pop when ext_out_valid && ext_out_ready.
  - ext_out_data = head; ext_out_valid = !out_empty.
  - Latency: out_strobe at edge N -> ext_out_valid high after edge N when the FIFO was empty.
- Pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare.
- Stickies clear only on reset.
- IRQ FSM, states IDLE, ASSERT, HOLDOFF:
  - IDLE -> ASSERT when irq_enable && !in_empty && !irq_served; sets irq_served, loads counter=IRQ_PULSE-1.
  - ASSERT: interrupt_signal=1; counter decrements; at 0 -> HOLDOFF, counter=IRQ_HOLDOFF-1.
  - HOLDOFF: interrupt_signal=0; at 0 -> IDLE.
  - irq_served clears in any state on a cycle where the input FIFO becomes empty. One interrupt per empty->non-empty episode.
  - irq_enable dropping mid-ASSERT does not truncate the pulse.
  - Push into empty FIFO at edge N with irq_enable=1 in IDLE -> interrupt_signal high after edge N+1, for IRQ_PULSE cycles.

Optional Feature:
- Macro IO_LOOPBACK_EN adds input port loopback (1 bit).
- With the macro and loopback=1: out_strobe pushes out_port into the input FIFO instead of the output FIFO. Overflow rules and out_overflow apply against input-FIFO full. ext_in_ready is forced 0.
- Without the macro: no loopback port; behaviour as above.

Decomposition:
- Package io_port_pkg: DATA_W default constant, irq_state_t enum (IDLE, ASSERT, HOLDOFF), pointer-width helper function.
- One sub-module io_sync_fifo (DEPTH, WIDTH; push, pop, full, empty, head, count), instantiated for input and output FIFOs. IRQ FSM and sticky logic live in the top.

Test Plan:
- Reset mid-stream: push 3 words, assert rst low -> ext_out_valid=0, input_port=0, interrupt_signal=0 immediately; FIFOs empty after release.
- Push 0x1234, 0xBEEF with irq_enable=1 -> input_port=0x1234, interrupt_signal high 2 cycles, then low. in_consume -> input_port=0xBEEF; second in_consume -> FIFO empty, input_port holds 0xBEEF, no new interrupt until a later push.
- Fill input FIFO with 8 words -> ext_in_ready=0. Simultaneous push+pop when count=7 -> count stays 7. Ninth word not accepted. in_consume on empty -> in_underflow=1.
- 9 out_strobes (0x0001..0x0009) with ext_out_ready=0 -> 8 buffered, out_overflow=1. Release ready -> sink receives 0x0001..0x0008 in order.
- Empty/refill within HOLDOFF: pop to empty then push during HOLDOFF -> second pulse starts only after HOLDOFF expires.
- IO_LOOPBACK_EN, loopback=1: out_strobe with out_port=0x00A5 -> input_port=0x00A5 next cycle, ext_out_valid stays 0, ext_in_ready=0.
